// File: rtl/mem_if_pkg.sv
// Shared definitions for the cache <-> main memory refill/writeback handshake.
// Both the cache FSM and the memory responder import this so latencies agree.
package mem_if_pkg;

    localparam int WORD_W                = 32;
    localparam int CNT_W                 = 4;
    localparam int DEFAULT_READ_LATENCY  = 4;
    localparam int DEFAULT_WRITE_LATENCY = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        RD_DONE = 3'd2,
        WR_WAIT = 3'd3,
        WR_DONE = 3'd4
    } stateT;

    // Latency is counted down to zero, so the loaded value is one less.
    function automatic logic [CNT_W-1:0] latencyLoad(input int latency);
        return CNT_W'(latency - 1);
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous word RAM, read-first, registered read output.
module mem_array
    import mem_if_pkg::*;
#(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] idx,
    input  logic [WORD_W-1:0]    wdata,
    output logic [WORD_W-1:0]    rdata
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    logic [WORD_W-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
        rdata <= mem[idx];
    end

endmodule

// File: rtl/main_memory_responder.sv
// Memory-side responder: fixed-latency word memory answering cache read/write
// requests and holding memDataReady until the cache returns dataGrabbed.
module main_memory_responder
    import mem_if_pkg::*;
#(
    parameter int ADDR_BITS     = 10,
    parameter int READ_LATENCY  = DEFAULT_READ_LATENCY,
    parameter int WRITE_LATENCY = DEFAULT_WRITE_LATENCY
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    input  logic        readMem,
    input  logic        writeMem,
    input  logic        dataGrabbed,
    output logic [31:0] readData,
    output logic        memDataReady,
    output logic        busy
);

    stateT                 stateReg,     stateNext;
    logic [CNT_W-1:0]      countReg,     countNext;
    logic [ADDR_BITS-1:0]  idxReg,       idxNext;
    logic [WORD_W-1:0]     wdataReg,     wdataNext;
    logic [WORD_W-1:0]     readDataReg,  readDataNext;
    logic                  readyReg,     readyNext;

    logic [ADDR_BITS-1:0]  reqIdx;
    logic [ADDR_BITS-1:0]  ramIdx;
    logic                  ramWe;
    logic [WORD_W-1:0]     ramRdata;
    logic                  unusedAddrBits;

    assign reqIdx         = address[ADDR_BITS+1:2];
    assign unusedAddrBits = ^{address[31:ADDR_BITS+2], address[1:0]};

    // In IDLE the RAM already looks up the incoming address, so the word is
    // sitting in ramRdata one edge after acceptance even for latency 1.
    assign ramIdx = (stateReg == IDLE) ? reqIdx : idxReg;

    mem_array #(
        .ADDR_BITS (ADDR_BITS)
    ) u_memArray (
        .clk   (clk),
        .we    (ramWe),
        .idx   (ramIdx),
        .wdata (wdataReg),
        .rdata (ramRdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg    <= IDLE;
            countReg    <= '0;
            idxReg      <= '0;
            wdataReg    <= '0;
            readDataReg <= '0;
            readyReg    <= 1'b0;
        end else begin
            stateReg    <= stateNext;
            countReg    <= countNext;
            idxReg      <= idxNext;
            wdataReg    <= wdataNext;
            readDataReg <= readDataNext;
            readyReg    <= readyNext;
        end
    end

    always_comb begin
        stateNext    = stateReg;
        countNext    = countReg;
        idxNext      = idxReg;
        wdataNext    = wdataReg;
        readDataNext = readDataReg;
        readyNext    = readyReg;
        ramWe        = 1'b0;

        case (stateReg)
            IDLE: begin
                // A simultaneous read is dropped; the cache re-requests it.
                if (writeMem) begin
                    stateNext = WR_WAIT;
                    countNext = latencyLoad(WRITE_LATENCY);
                    idxNext   = reqIdx;
                    wdataNext = writeData;
                end else if (readMem) begin
                    stateNext = RD_WAIT;
                    countNext = latencyLoad(READ_LATENCY);
                    idxNext   = reqIdx;
                end
            end
            RD_WAIT: begin
                if (countReg == '0) begin
                    readDataNext = ramRdata;
                    readyNext    = 1'b1;
                    stateNext    = RD_DONE;
                end else begin
                    countNext = countReg - 1'b1;
                end
            end
            WR_WAIT: begin
                if (countReg == '0) begin
                    ramWe     = 1'b1;
                    readyNext = 1'b1;
                    stateNext = WR_DONE;
                end else begin
                    countNext = countReg - 1'b1;
                end
            end
            RD_DONE, WR_DONE: begin
                if (dataGrabbed) begin
                    readyNext = 1'b0;
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
                readyNext = 1'b0;
            end
        endcase
    end

    assign readData     = readDataReg;
    assign memDataReady = readyReg;
    assign busy         = (stateReg != IDLE);

endmodule

// File: tb/tb_main_memory_responder.sv
// Directed scoreboard bench for main_memory_responder (latency 4/4, 10-bit index).
module tb_main_memory_responder;

    localparam int ADDR_BITS = 10;
    localparam int RD_LAT    = 4;
    localparam int WR_LAT    = 4;
    localparam int DEPTH     = 2 ** ADDR_BITS;
    localparam int MAX_WAIT  = 40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] writeData = '0;
    logic        readMem = 1'b0;
    logic        writeMem = 1'b0;
    logic        dataGrabbed = 1'b0;
    logic [31:0] readData;
    logic        memDataReady;
    logic        busy;

    typedef struct {
        string       tag;
        bit          isRead;
        int          lat;
        logic [31:0] data;
    } expT;

    expT         sbq[$];
    logic [31:0] model [int];
    logic [31:0] lastRead = '0;
    int          compared = 0;
    int          mismatched = 0;

    main_memory_responder #(
        .ADDR_BITS     (ADDR_BITS),
        .READ_LATENCY  (RD_LAT),
        .WRITE_LATENCY (WR_LAT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .address      (address),
        .writeData    (writeData),
        .readMem      (readMem),
        .writeMem     (writeMem),
        .dataGrabbed  (dataGrabbed),
        .readData     (readData),
        .memDataReady (memDataReady),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Waits for memDataReady after an acceptance edge and scores it against the queue head.
    task automatic waitResp();
        expT e;
        int  edges = 0;
        while (edges < MAX_WAIT) begin
            @(posedge clk);
            edges++;
            #1;
            if (memDataReady) break;
        end
        e = sbq.pop_front();
        check({e.tag, "_ready"}, {31'd0, memDataReady}, 32'd1);
        check({e.tag, "_latency"}, edges, e.lat);
        check({e.tag, "_readData"}, readData, e.data);
        $display("txn %s %s latency=%0d readData=%h", e.tag, e.isRead ? "RD" : "WR", edges, readData);
    endtask

    task automatic doReq(input string tag, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wd);
        expT e;
        int  idx = int'((addr >> 2) & (DEPTH - 1));
        e.tag = tag;
        if (wr) begin
            e.isRead   = 1'b0;
            e.lat      = WR_LAT;
            e.data     = lastRead;
            model[idx] = wd;
        end else begin
            e.isRead = 1'b1;
            e.lat    = RD_LAT;
            e.data   = model.exists(idx) ? model[idx] : 32'hx;
            lastRead = e.data;
        end
        sbq.push_back(e);
        @(negedge clk);
        address   = addr;
        writeData = wd;
        readMem   = rd;
        writeMem  = wr;
        @(posedge clk);
        #1;
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        @(negedge clk);
        readMem  = 1'b0;
        writeMem = 1'b0;
        waitResp();
    endtask

    task automatic grab(input string tag);
        @(negedge clk);
        dataGrabbed = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_grab_ready"}, {31'd0, memDataReady}, 32'd0);
        check({tag, "_grab_busy"}, {31'd0, busy}, 32'd0);
        @(negedge clk);
        dataGrabbed = 1'b0;
    endtask

    initial begin
        // Reset held with readMem high
        readMem = 1'b1;
        address = 32'h40;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, memDataReady}, 32'd0);
        check("rst_readData", readData, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        readMem = 1'b0;
        rst_n   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            check("post_rst_idle", {30'd0, busy, memDataReady}, 32'd0);
        end

        // Write then read
        doReq("wr40", 1'b0, 1'b1, 32'h40, 32'hDEADBEEF);
        grab("wr40");
        doReq("rd40", 1'b1, 1'b0, 32'h40, 32'h0);

        // Held acknowledge, stray read ignored
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            address = (i == 3 || i == 4) ? 32'h80 : 32'h40;
            readMem = (i == 3 || i == 4);
            @(posedge clk);
            #1;
            check("hold_ready", {31'd0, memDataReady}, 32'd1);
            check("hold_readData", readData, 32'hDEADBEEF);
        end
        grab("rd40_held");
        @(posedge clk);
        #1;
        check("stray_read_ignored", {31'd0, busy}, 32'd0);

        // Simultaneous read+write: write wins
        doReq("both10", 1'b1, 1'b1, 32'h10, 32'h12345678);
        grab("both10");
        doReq("rd10", 1'b1, 1'b0, 32'h10, 32'h0);
        grab("rd10");

        // Wrap and alignment
        doReq("wr1003", 1'b0, 1'b1, 32'h1003, 32'hA5A5A5A5);
        grab("wr1003");
        doReq("rd0000", 1'b1, 1'b0, 32'h0, 32'h0);
        grab("rd0000");

        // Abort a write in WR_WAIT
        doReq("wr20", 1'b0, 1'b1, 32'h20, 32'h11111111);
        grab("wr20");
        @(negedge clk);
        address   = 32'h20;
        writeData = 32'h55;
        writeMem  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        writeMem = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_ready", {31'd0, memDataReady}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        lastRead = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            check("abort_no_resp", {31'd0, memDataReady}, 32'd0);
        end
        doReq("rd20", 1'b1, 1'b0, 32'h20, 32'h0);

        // Reset while in RD_DONE drops memDataReady at once
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("done_rst_ready", {31'd0, memDataReady}, 32'd0);
        check("done_rst_readData", readData, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        check("scoreboard_empty", sbq.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/main_memory_responder.md
Name: main_memory_responder

Overview:
- Responder (memory-side) end of the cache-to-main-memory refill/writeback handshake.
- The data cache initiates with readMem/writeMem; this block models main memory with a fixed multi-cycle latency.
- It raises memDataReady when read data is valid or a write has committed, and holds it until the cache returns dataGrabbed.
- Replaces the combinational main-memory model behind the data cache.

Parameters:
- ADDR_BITS, 10, word-address width; memory depth = 2**ADDR_BITS 32-bit words.
- READ_LATENCY, 4, cycles from request acceptance to memDataReady for reads; legal range 1..15.
- WRITE_LATENCY, 4, cycles from request acceptance to memDataReady for writes; legal range 1..15.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- address  in  32  byte address from the cache; word index = address[ADDR_BITS+1:2].
- writeData  in  32  word to store on a write request.
- readMem  in  1  read request from the cache.
- writeMem  in  1  write request from the cache.
- dataGrabbed  in  1  cache acknowledge that it consumed the response.
- readData  out  32  read result; valid while memDataReady=1 after a read.
- memDataReady  out  1  response valid (read data valid, or write committed).
- busy  out  1  high in every state except IDLE.

Behaviour:
- Clocking and reset:
  - One clock domain.
  - rst_n low asynchronously forces state=IDLE, memDataReady=0, readData=0, busy=0, and latency counter=0.
  - Memory array contents are not reset.
- States: IDLE, RD_WAIT, RD_DONE, WR_WAIT, WR_DONE.
- IDLE:
  - Samples readMem/writeMem every edge.
  - If both are high, writeMem wins and readMem is ignored; the cache must re-request the read.
  - On acceptance, address, writeData and the request type are latched. Request lines may drop after the accepting edge.
  - Counter is loaded with LATENCY-1.
- RD_WAIT:
  - Counter decrements each edge.
  - At count 0: readData <= mem[latched index], memDataReady <= 1, go to RD_DONE.
  - Net timing: a request accepted at edge N gives memDataReady high after edge N+READ_LATENCY.
- WR_WAIT:
  - Same counting as RD_WAIT.
  - At count 0: mem[latched index] <= latched writeData, memDataReady <= 1, go to WR_DONE.
  - The write commits on that edge only.
- RD_DONE / WR_DONE:
  - memDataReady and readData are held stable.
  - readData is unchanged in WR_DONE and keeps its last read value.
  - When dataGrabbed is sampled high: memDataReady <= 0, go to IDLE.
  - New requests are ignored in these states.
  - No timeout; the block waits indefinitely for dataGrabbed.
- Back-to-back handling:
  - A request still high in the first IDLE cycle after DONE is accepted as a new request.
  - The initiator must drop its request on seeing memDataReady to avoid a duplicate.
  - Minimum request-to-request spacing is LATENCY+2 cycles.
- dataGrabbed outside the DONE states is ignored.
- Address handling:
  - address[1:0] is ignored (word access only).
  - Bits above ADDR_BITS+1 are ignored, so the address wraps modulo depth.
- Reset mid-operation:
  - A write aborted in WR_WAIT is never committed.
  - A read aborted in RD_WAIT produces no response.
  - A reset in a DONE state drops memDataReady immediately.
- Latency arithmetic:
  - The counter is 4 bits wide.
  - LATENCY=1 loads 0, so the response asserts on the first edge after acceptance.

Decomposition:
- Shared package mem_if_pkg:
  - state enum (IDLE, RD_WAIT, RD_DONE, WR_WAIT, WR_DONE);
  - WORD_W=32;
  - default latency constants, shared with the cache FSM so both ends agree.
- One sub-module mem_array:
  - single-port synchronous word RAM (clk, we, idx, wdata, rdata);
  - read and write on a clock edge;
  - optional init file for program/data preload.
- The FSM and counter stay in main_memory_responder.

Test Plan:
- Reset: rst_n=0 for 3 cycles while readMem=1 -> memDataReady=0, readData=0, busy=0, and no response after release until a fresh acceptance.
- Write then read: write address=0x40, writeData=0xDEADBEEF (1-cycle pulse), latency 4:
  - memDataReady rises exactly 4 edges after acceptance;
  - dataGrabbed a cycle later -> memDataReady drops;
  - read 0x40 -> readData=0xDEADBEEF with memDataReady after 4 edges.
- Held ack: after a read of 0x40, keep dataGrabbed=0 for 10 cycles -> memDataReady and readData stay stable; a readMem pulse on 0x80 during this time is ignored.
- Simultaneous request: readMem=writeMem=1, address=0x10, writeData=0x12345678 -> the write commits; a subsequent read of 0x10 returns 0x12345678.
- Wrap and alignment (ADDR_BITS=10): write 0xA5A5A5A5 to 0x1003 -> a read of 0x0000 returns 0xA5A5A5A5.
- Abort: start a write of 0x55 to 0x20, assert rst_n=0 at the 2nd wait cycle -> memDataReady never rises; a later read of 0x20 returns the prior contents.
